seg7_scan_decoder: RTL and testbench

- Receives a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit enables) and recovers the hex value being shown.
- It is the decode side of the team's hex-to-7-segment encoding.
- Used for board loopback: it checks the ALU/accumulator display path and feeds the displayed value back to logic.
- It filters glitches, decodes each digit, assembles a full frame and flags illegal patterns.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_to_hex.sv | 26 ++
 rtl/seg7_scan_decoder.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg: shared active-low segment table, blank code and decoder states.
// Rev 1.0
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry h is the active-low pattern for hex digit h (bit0=a .. bit6=g).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
// seg7_to_hex: combinational active-low segment pattern to nibble decoder.
// Rev 1.0
// ============================================================================
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       illegal_o
);

  always_comb begin
    nibble_o  = 4'h0;
    illegal_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_n_i == SEG_TABLE[i]) begin
        nibble_o  = 4'(i);
        illegal_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder: filters a scanned 7-segment bus and rebuilds the frame.
// Rev 1.0
// ============================================================================
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_err,
  output logic                    frame_valid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [6:0]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   den_q, den_prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    same, capture;
  logic [IDX_W-1:0]        cap_idx;
  logic [3:0]              dec_nib;
  logic                    dec_ill;

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, base_mask, new_mask;
  logic [4*NUM_DIGITS-1:0] pend_nib_q, pend_nib_d;
  logic [NUM_DIGITS-1:0]   pend_err_q, pend_err_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [IDX_W-1:0]        hold_idx_q, hold_idx_d;
  logic [3:0]              hold_nib_q, hold_nib_d;
  logic                    hold_err_q, hold_err_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   derr_q, derr_d;
  logic                    ferr_q, ferr_d;

  logic                    evt_vld;
  logic [IDX_W-1:0]        evt_idx;
  logic [3:0]              evt_nib;
  logic                    evt_err;

  seg7_to_hex u_dec (
    .seg_n_i   (seg_q),
    .nibble_o  (dec_nib),
    .illegal_o (dec_ill)
  );

  assign same    = (seg_q == seg_prev_q) && (den_q == den_prev_q);
  // Fires on the single cycle the counter steps into STABLE_CYCLES-1.
  assign capture = same && (cnt_q == CNT_FIRE) && $onehot(den_q) && (seg_q != SEG_BLANK);

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (den_q[i]) cap_idx = IDX_W'(i);
    end
  end

  // A capture parked during DONE is replayed as the first event in IDLE.
  always_comb begin
    evt_vld = capture;
    evt_idx = cap_idx;
    evt_nib = dec_nib;
    evt_err = dec_ill;
    if (state_q == IDLE && hold_vld_q) begin
      evt_vld = 1'b1;
      evt_idx = hold_idx_q;
      evt_nib = hold_nib_q;
      evt_err = hold_err_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pend_nib_d = pend_nib_q;
    pend_err_d = pend_err_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;
    hold_nib_d = hold_nib_q;
    hold_err_d = hold_err_q;
    value_d    = value_q;
    derr_d     = derr_q;
    ferr_d     = ferr_q;
    base_mask  = mask_q;
    new_mask   = mask_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == IDLE) hold_vld_d = 1'b0;
        if (evt_vld) begin
          if (state_q == IDLE || mask_q[evt_idx]) begin
            base_mask  = '0;
            pend_nib_d = '0;
            pend_err_d = '0;
          end
          new_mask                   = base_mask;
          new_mask[evt_idx]          = 1'b1;
          pend_nib_d[4*evt_idx +: 4] = evt_nib;
          pend_err_d[evt_idx]        = evt_err;
          mask_d                     = new_mask;
          if (new_mask == ALL_SEEN) begin
            state_d = DONE;
            value_d = pend_nib_d;
            derr_d  = pend_err_d;
            ferr_d  = |pend_err_d;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      DONE: begin
        mask_d  = '0;
        state_d = IDLE;
        if (capture) begin
          hold_vld_d = 1'b1;
          hold_idx_d = cap_idx;
          hold_nib_d = dec_nib;
          hold_err_d = dec_ill;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q      <= '0;
      den_q      <= '0;
      seg_prev_q <= '0;
      den_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      mask_q     <= '0;
      pend_nib_q <= '0;
      pend_err_q <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
      hold_nib_q <= '0;
      hold_err_q <= 1'b0;
      value_q    <= '0;
      derr_q     <= '0;
      ferr_q     <= 1'b0;
    end else begin
      seg_q      <= seg_n;
      den_q      <= dig_en;
      seg_prev_q <= seg_q;
      den_prev_q <= den_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_nib_q <= pend_nib_d;
      pend_err_q <= pend_err_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
      hold_nib_q <= hold_nib_d;
      hold_err_q <= hold_err_d;
      value_q    <= value_d;
      derr_q     <= derr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = derr_q;
  assign frame_err   = ferr_q;
  assign frame_valid = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_decoder: table-driven, directed and random checks of the decoder.
// Rev 1.0
// ============================================================================
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int ST = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_err;
  logic        frame_valid;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .dig_en      (dig_en),
    .value       (value),
    .digit_err   (digit_err),
    .frame_err   (frame_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  logic [6:0] ref_pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] pat(input int h);
    return ref_pat[h];
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: run-length of the bus pair, capture after ST equal cycles,
  // frame assembled from per-digit slots.
  logic [10:0] m_last  = '0;
  int          m_run   = 0;
  logic        m_cap   = 1'b0;
  int          m_cidx  = 0;
  logic [3:0]  m_cnib  = '0;
  logic        m_cerr  = 1'b0;
  logic [3:0]  m_seen  = '0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_err   = '0;
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_derr  = '0;
  logic        exp_ferr  = 1'b0;
  logic        exp_fv    = 1'b0;

  initial begin : model
    logic [10:0] bus;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_last = '0; m_run = 0; m_cap = 1'b0; m_seen = '0; m_err = '0;
        exp_value = '0; exp_derr = '0; exp_ferr = 1'b0; exp_fv = 1'b0;
      end else begin
        exp_fv = 1'b0;
        if (m_cap) begin
          if (m_seen[m_cidx]) begin
            m_seen = '0;
            m_err  = '0;
          end
          m_seen[m_cidx] = 1'b1;
          m_nib[m_cidx]  = m_cnib;
          m_err[m_cidx]  = m_cerr;
          if (m_seen == 4'b1111) begin
            for (int d = 0; d < 4; d++) exp_value[4*d +: 4] = m_nib[d];
            exp_derr = m_err;
            exp_ferr = |m_err;
            exp_fv   = 1'b1;
            m_seen   = '0;
          end
        end
        bus = {dig_en, seg_n};
        if (bus == m_last) m_run++;
        else m_run = 1;
        m_last = bus;
        m_cap = (m_run == ST) && $onehot(dig_en) && (seg_n != BLANK);
        if (m_cap) begin
          for (int d = 0; d < 4; d++) if (dig_en[d]) m_cidx = d;
          m_cnib = 4'h0;
          m_cerr = 1'b1;
          for (int h = 0; h < 16; h++) begin
            if (seg_n == ref_pat[h]) begin
              m_cnib = 4'(h);
              m_cerr = 1'b0;
            end
          end
        end
      end
    end
  end

  int          fv_cnt = 0;
  logic [15:0] fv_value = '0;
  logic [3:0]  fv_derr = '0;
  logic        fv_ferr = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      check("cycle_outputs", {10'd0, frame_valid, frame_err, digit_err, value},
            {10'd0, exp_fv, exp_ferr, exp_derr, exp_value});
      if (frame_valid) begin
        fv_cnt++;
        fv_value = value;
        fv_derr  = digit_err;
        fv_ferr  = frame_err;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    dig_en = en;
    seg_n  = seg;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0][6:0] seg;
    int              hold;
    logic [15:0]     val;
    logic [3:0]      derr;
    logic            ferr;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    int base;
    int lat;
    int sel;
    logic [3:0] ren;
    logic [6:0] rseg;

    vecs[0] = '{seg: {pat(10), pat(0), pat(12), pat(3)}, hold: 6,
                val: 16'hA0C3, derr: 4'b0000, ferr: 1'b0};
    vecs[1] = '{seg: {pat(15), 7'b1010101, pat(2), pat(1)}, hold: 5,
                val: 16'hF021, derr: 4'b0100, ferr: 1'b1};
    vecs[2] = '{seg: {pat(13), pat(11), pat(9), pat(8)}, hold: 4,
                val: 16'hDB98, derr: 4'b0000, ferr: 1'b0};
    vecs[3] = '{seg: {pat(7), pat(6), pat(5), pat(4)}, hold: 7,
                val: 16'h7654, derr: 4'b0000, ferr: 1'b0};
    vecs[4] = '{seg: {pat(0), 7'b0000001, 7'b0111111, pat(14)}, hold: 6,
                val: 16'h000E, derr: 4'b0110, ferr: 1'b1};

    reset  = 1'b1;
    dig_en = '0;
    seg_n  = BLANK;
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, frame_valid, frame_err, digit_err, value}, 32'd0);
    reset = 1'b0;
    drive(4'b0000, BLANK, 3);

    for (int v = 0; v < 5; v++) begin
      base = fv_cnt;
      for (int d = 0; d < 4; d++) drive(4'(1 << d), vecs[v].seg[d], vecs[v].hold);
      drive(4'b0000, BLANK, 6);
      check($sformatf("vec%0d_frames", v), fv_cnt - base, 1);
      check($sformatf("vec%0d_value", v), fv_value, vecs[v].val);
      check($sformatf("vec%0d_digit_err", v), fv_derr, vecs[v].derr);
      check($sformatf("vec%0d_frame_err", v), fv_ferr, vecs[v].ferr);
    end

    // Frame latency measured from the final digit's first bus cycle.
    base = fv_cnt;
    drive(4'b0001, pat(1), 6);
    drive(4'b0010, pat(2), 6);
    drive(4'b0100, pat(3), 6);
    dig_en = 4'b1000;
    seg_n  = pat(4);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (frame_valid) lat = k;
    end
    check("latency", lat, ST + 1);
    drive(4'b0000, BLANK, 4);
    check("latency_frames", fv_cnt - base, 1);
    check("latency_value", fv_value, 16'h4321);

    // Dwell of ST-1 cycles on digit 1 must not capture.
    base = fv_cnt;
    drive(4'b0001, pat(3), 6);
    drive(4'b0010, pat(1), ST - 1);
    drive(4'b0100, pat(5), 6);
    drive(4'b1000, pat(7), 6);
    drive(4'b0000, BLANK, 6);
    check("short_dwell_no_frame", fv_cnt - base, 0);
    drive(4'b0010, pat(1), ST);
    drive(4'b0000, BLANK, 6);
    check("short_dwell_frames", fv_cnt - base, 1);
    check("short_dwell_value", fv_value, 16'h7513);

    // Repeated digit 0 restarts the partial frame.
    base = fv_cnt;
    drive(4'b0001, pat(2), 6);
    drive(4'b0010, pat(4), 6);
    drive(4'b0001, pat(5), 6);
    drive(4'b0010, pat(6), 6);
    drive(4'b0100, pat(8), 6);
    drive(4'b1000, pat(9), 6);
    drive(4'b0000, BLANK, 6);
    check("restart_frames", fv_cnt - base, 1);
    check("restart_value", fv_value, 16'h9865);

    // Non-one-hot, blank and zero enables are ignored; partial frame survives.
    base = fv_cnt;
    drive(4'b0001, pat(10), 6);
    drive(4'b0011, pat(3), 10);
    drive(4'b0001, BLANK, 10);
    drive(4'b0000, pat(8), 10);
    check("ignored_no_frame", fv_cnt - base, 0);
    drive(4'b0010, pat(1), 6);
    drive(4'b0100, pat(2), 6);
    drive(4'b1000, pat(3), 6);
    drive(4'b0000, BLANK, 6);
    check("ignored_frames", fv_cnt - base, 1);
    check("ignored_value", fv_value, 16'h321A);

    // Asynchronous reset mid-frame.
    drive(4'b0001, pat(7), 6);
    drive(4'b0010, pat(8), 6);
    #2;
    reset  = 1'b1;
    dig_en = '0;
    seg_n  = BLANK;
    #1;
    check("async_reset_outputs", {11'd0, frame_valid, frame_err, digit_err, value}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    base = fv_cnt;
    drive(4'b0100, pat(0), 6);
    drive(4'b1000, pat(10), 6);
    drive(4'b0000, BLANK, 6);
    check("post_reset_partial", fv_cnt - base, 0);
    drive(4'b0001, pat(3), 6);
    drive(4'b0010, pat(12), 6);
    drive(4'b0000, BLANK, 6);
    check("post_reset_frames", fv_cnt - base, 1);
    check("post_reset_value", fv_value, 16'hA0C3);

    // Random bus traffic against the reference model.
    for (int r = 0; r < 400; r++) begin
      sel = $urandom_range(0, 99);
      ren = (sel < 88) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 99);
      if (sel < 80)      rseg = pat($urandom_range(0, 15));
      else if (sel < 95) rseg = 7'($urandom_range(0, 127));
      else               rseg = BLANK;
      drive(ren, rseg, $urandom_range(1, 7));
    end
    drive(4'b0000, BLANK, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
